// File: rtl/controle_operacional.sv
// controle_operacional: IDLE/LOAD/EXEC/DONE sequencer driving selA/wrA/wrB/aluOp of the register/ALU datapath, with busy/done status
module controle_operacional #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             selA,
  output logic             wrA,
  output logic             wrB,
  output logic [1:0]       aluOp,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, EXEC = 2'd2, DONE = 2'd3;
  logic [1:0] state, nxt;
  logic [1:0] op_q;
  logic [CNT_W-1:0] cnt_q;
  always_comb begin
    nxt = state == IDLE ? (start ? LOAD : IDLE)
        : state == LOAD ? (abort ? IDLE : cnt_q == '0 ? DONE : EXEC)
        : state == EXEC ? (abort ? IDLE : cnt_q <= CNT_W'(1) ? DONE : EXEC)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        op_q  <= op;
        cnt_q <= count;
      end else if (state == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end
  assign selA  = state == LOAD;
  assign wrA   = state == LOAD || state == EXEC;
  assign wrB   = state == LOAD;
  assign busy  = state == LOAD || state == EXEC;
  assign done  = state == DONE;
  assign aluOp = state == IDLE ? 2'b00 : op_q;
endmodule
